// File: rtl/pulse_frame_checker.sv
// pulse_frame_checker
//
// Receive-side monitor for the single-wire pulse line produced by the
// trigger-to-pulse generator. Each pulse must be exactly HIGH_LEN cycles high.
// It must then be followed by at least GAP_LEN low cycles. A good pulse
// produces a one-cycle pulse_ok strobe and bumps a saturating ok_count. Each
// class of malformed pulse gets its own one-cycle error strobe. The checker
// shares the generator's clock domain, so y_in is sampled directly.
//
// Optional feature: define PULSE_CHK_ERRCNT_EN to add err_count (saturating
// count of error strobes) and err_sticky (set by any error strobe).
//
// Ports:
//   clock      in   rising-edge clock
//   reset      in   asynchronous, active-low reset
//   clr        in   synchronous clear of the counters (FSM unaffected)
//   y_in       in   monitored pulse line
//   busy       out  high whenever the FSM is not idle
//   pulse_ok   out  strobe: valid pulse and gap completed
//   err_short  out  strobe: high phase ended before HIGH_LEN
//   err_long   out  strobe: high phase exceeded HIGH_LEN
//   err_gap    out  strobe: line rose again before GAP_LEN low cycles
//   ok_count   out  saturating count of pulse_ok strobes
//   err_count  out  (PULSE_CHK_ERRCNT_EN) saturating count of error strobes
//   err_sticky out  (PULSE_CHK_ERRCNT_EN) set by any error, cleared by reset/clr

module pulse_frame_checker #(
    parameter int unsigned HIGH_LEN = 3,
    parameter int unsigned GAP_LEN  = 2,
    parameter int unsigned LEN_W    = 4,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr,
    input  logic             y_in,
    output logic             busy,
    output logic             pulse_ok,
    output logic             err_short,
    output logic             err_long,
    output logic             err_gap,
    output logic [CNT_W-1:0] ok_count
`ifdef PULSE_CHK_ERRCNT_EN
    ,
    output logic [CNT_W-1:0] err_count,
    output logic             err_sticky
`endif
);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StHigh    = 2'd1,
        StGap     = 2'd2,
        StRecover = 2'd3
    } state_e;

    localparam logic [LEN_W-1:0] HighLenC = LEN_W'(HIGH_LEN);
    localparam logic [LEN_W-1:0] GapLastC = LEN_W'(GAP_LEN - 1);
    localparam logic [LEN_W-1:0] OneC     = LEN_W'(1);

    state_e           state_q, state_d;
    logic [LEN_W-1:0] hcnt_q, hcnt_d;
    logic [LEN_W-1:0] gcnt_q, gcnt_d;
    logic             ok_d, short_d, long_d, gap_d;

    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        gcnt_d  = gcnt_q;
        ok_d    = 1'b0;
        short_d = 1'b0;
        long_d  = 1'b0;
        gap_d   = 1'b0;
        case (state_q)
            StIdle: begin
                if (y_in) begin
                    state_d = StHigh;
                    hcnt_d  = OneC;
                end
            end
            StHigh: begin
                if (y_in) begin
                    if (hcnt_q < HighLenC) begin
                        hcnt_d = hcnt_q + OneC;
                    end else begin
                        long_d  = 1'b1;
                        state_d = StRecover;
                    end
                end else if (hcnt_q < HighLenC) begin
                    short_d = 1'b1;
                    state_d = StIdle;
                end else if (GAP_LEN == 1) begin
                    // A single-cycle gap is already satisfied by the falling sample.
                    ok_d    = 1'b1;
                    state_d = StIdle;
                end else begin
                    state_d = StGap;
                    gcnt_d  = OneC;
                end
            end
            StGap: begin
                if (y_in) begin
                    // Early rise is taken as the first high cycle of a new pulse.
                    gap_d   = 1'b1;
                    state_d = StHigh;
                    hcnt_d  = OneC;
                end else if (gcnt_q < GapLastC) begin
                    gcnt_d = gcnt_q + OneC;
                end else begin
                    ok_d    = 1'b1;
                    state_d = StIdle;
                end
            end
            StRecover: begin
                if (!y_in) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            hcnt_q    <= '0;
            gcnt_q    <= '0;
            pulse_ok  <= 1'b0;
            err_short <= 1'b0;
            err_long  <= 1'b0;
            err_gap   <= 1'b0;
        end else begin
            state_q   <= state_d;
            hcnt_q    <= hcnt_d;
            gcnt_q    <= gcnt_d;
            pulse_ok  <= ok_d;
            err_short <= short_d;
            err_long  <= long_d;
            err_gap   <= gap_d;
        end
    end

    assign busy = (state_q != StIdle);

    // clr wins over a same-cycle increment; the count holds at all-ones.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ok_count <= '0;
        end else if (clr) begin
            ok_count <= '0;
        end else if (ok_d && (ok_count != {CNT_W{1'b1}})) begin
            ok_count <= ok_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

`ifdef PULSE_CHK_ERRCNT_EN
    logic err_any;

    assign err_any = short_d | long_d | gap_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            err_count  <= '0;
            err_sticky <= 1'b0;
        end else if (clr) begin
            err_count  <= '0;
            err_sticky <= 1'b0;
        end else if (err_any) begin
            err_sticky <= 1'b1;
            if (err_count != {CNT_W{1'b1}}) begin
                err_count <= err_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end
`endif

endmodule

// File: tb/tb_pulse_frame_checker.sv
// Directed bench for pulse_frame_checker. Three instances share the stimulus:
// dut_a uses the default parameters, dut_b uses CNT_W=2 to reach saturation,
// and dut_c uses GAP_LEN=1 for the single-cycle-gap case.

module tb_pulse_frame_checker;

    logic clock;
    logic reset;
    logic clr;
    logic y_in;

    logic       a_busy, a_ok, a_short, a_long, a_gap;
    logic [7:0] a_cnt;
    logic       b_busy, b_ok, b_short, b_long, b_gap;
    logic [1:0] b_cnt;
    logic       c_busy, c_ok, c_short, c_long, c_gap;
    logic [7:0] c_cnt;
    logic [2:0] a_err;
    logic [2:0] c_err;
`ifdef PULSE_CHK_ERRCNT_EN
    logic [7:0] a_ecnt, c_ecnt;
    logic [1:0] b_ecnt;
    logic       a_sticky, b_sticky, c_sticky;
`endif

    int n_checks;
    int n_fail;

    assign a_err = {a_short, a_long, a_gap};
    assign c_err = {c_short, c_long, c_gap};

    pulse_frame_checker #(.HIGH_LEN(3), .GAP_LEN(2), .LEN_W(4), .CNT_W(8)) dut_a (
        .clock     (clock),
        .reset     (reset),
        .clr       (clr),
        .y_in      (y_in),
        .busy      (a_busy),
        .pulse_ok  (a_ok),
        .err_short (a_short),
        .err_long  (a_long),
        .err_gap   (a_gap),
        .ok_count  (a_cnt)
`ifdef PULSE_CHK_ERRCNT_EN
        ,
        .err_count (a_ecnt),
        .err_sticky(a_sticky)
`endif
    );

    pulse_frame_checker #(.HIGH_LEN(3), .GAP_LEN(2), .LEN_W(4), .CNT_W(2)) dut_b (
        .clock     (clock),
        .reset     (reset),
        .clr       (clr),
        .y_in      (y_in),
        .busy      (b_busy),
        .pulse_ok  (b_ok),
        .err_short (b_short),
        .err_long  (b_long),
        .err_gap   (b_gap),
        .ok_count  (b_cnt)
`ifdef PULSE_CHK_ERRCNT_EN
        ,
        .err_count (b_ecnt),
        .err_sticky(b_sticky)
`endif
    );

    pulse_frame_checker #(.HIGH_LEN(3), .GAP_LEN(1), .LEN_W(4), .CNT_W(8)) dut_c (
        .clock     (clock),
        .reset     (reset),
        .clr       (clr),
        .y_in      (y_in),
        .busy      (c_busy),
        .pulse_ok  (c_ok),
        .err_short (c_short),
        .err_long  (c_long),
        .err_gap   (c_gap),
        .ok_count  (c_cnt)
`ifdef PULSE_CHK_ERRCNT_EN
        ,
        .err_count (c_ecnt),
        .err_sticky(c_sticky)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Present v for the next rising edge, then return 1 time unit after it.
    task automatic step(input logic v);
        y_in = v;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            y_in = i[0];
            @(posedge clock);
            #1;
            n_checks++;
            if ({a_busy, a_ok, a_err, a_cnt, b_cnt} !== 15'd0) begin
                n_fail++;
                $display("FAIL reset_hold[%0d]: got busy=%b ok=%b err=%b cnt=%0d/%0d want all 0",
                         i, a_busy, a_ok, a_err, a_cnt, b_cnt);
            end
        end
        reset = 1'b1;
        step(1'b0);
        n_checks++;
        if ({a_busy, a_ok, a_err} !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_release: got busy=%b ok=%b err=%b want 0", a_busy, a_ok, a_err);
        end
    endtask

    task automatic test_nominal();
        step(1'b1);
        n_checks++;
        if (a_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL nominal_busy: got %b want 1", a_busy);
        end
        step(1'b1);
        step(1'b1);
        step(1'b0);
        n_checks++;
        if ({a_ok, a_err} !== 4'd0) begin
            n_fail++;
            $display("FAIL nominal_early: got ok=%b err=%b want 0", a_ok, a_err);
        end
        step(1'b0);
        n_checks++;
        if ({a_ok, a_err, a_cnt, b_cnt} !== {1'b1, 3'b000, 8'd1, 2'd1}) begin
            n_fail++;
            $display("FAIL nominal_ok: got ok=%b err=%b cnt=%0d/%0d want ok=1 err=000 cnt=1/1",
                     a_ok, a_err, a_cnt, b_cnt);
        end
        step(1'b0);
        n_checks++;
        if ({a_ok, a_busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL nominal_after: got ok=%b busy=%b want 0 0", a_ok, a_busy);
        end
    endtask

    task automatic test_short();
        step(1'b1);
        step(1'b1);
        step(1'b0);
        n_checks++;
        if ({a_err, a_ok, a_busy, a_cnt} !== {3'b100, 1'b0, 1'b0, 8'd1}) begin
            n_fail++;
            $display("FAIL short_strobe: got err=%b ok=%b busy=%b cnt=%0d want 100 0 0 1",
                     a_err, a_ok, a_busy, a_cnt);
        end
        step(1'b0);
        n_checks++;
        if (a_err !== 3'b000) begin
            n_fail++;
            $display("FAIL short_one_cycle: got err=%b want 000", a_err);
        end
`ifdef PULSE_CHK_ERRCNT_EN
        n_checks++;
        if ({a_ecnt, a_sticky} !== {8'd1, 1'b1}) begin
            n_fail++;
            $display("FAIL short_errcnt: got cnt=%0d sticky=%b want 1 1", a_ecnt, a_sticky);
        end
`endif
    endtask

    task automatic test_long();
        for (int i = 0; i < 3; i++) step(1'b1);
        n_checks++;
        if (a_err !== 3'b000) begin
            n_fail++;
            $display("FAIL long_early: got err=%b want 000", a_err);
        end
        step(1'b1);
        n_checks++;
        if ({a_err, a_busy} !== {3'b010, 1'b1}) begin
            n_fail++;
            $display("FAIL long_strobe: got err=%b busy=%b want 010 1", a_err, a_busy);
        end
        for (int i = 0; i < 2; i++) begin
            step(1'b1);
            n_checks++;
            if ({a_err, a_busy} !== {3'b000, 1'b1}) begin
                n_fail++;
                $display("FAIL long_recover[%0d]: got err=%b busy=%b want 000 1", i, a_err, a_busy);
            end
        end
        step(1'b0);
        n_checks++;
        if ({a_err, a_ok, a_busy} !== 5'd0) begin
            n_fail++;
            $display("FAIL long_exit: got err=%b ok=%b busy=%b want 0", a_err, a_ok, a_busy);
        end
        step(1'b0);
        n_checks++;
        if ({a_err, a_ok, a_cnt} !== {3'b000, 1'b0, 8'd1}) begin
            n_fail++;
            $display("FAIL long_idle: got err=%b ok=%b cnt=%0d want 000 0 1", a_err, a_ok, a_cnt);
        end
    endtask

    task automatic test_gap();
        for (int i = 0; i < 3; i++) step(1'b1);
        step(1'b0);
        step(1'b1);
        n_checks++;
        if ({a_err, a_busy} !== {3'b001, 1'b1}) begin
            n_fail++;
            $display("FAIL gap_strobe: got err=%b busy=%b want 001 1", a_err, a_busy);
        end
        step(1'b1);
        step(1'b1);
        step(1'b0);
        n_checks++;
        if ({a_err, a_ok} !== 4'd0) begin
            n_fail++;
            $display("FAIL gap_second_early: got err=%b ok=%b want 0", a_err, a_ok);
        end
        step(1'b0);
        n_checks++;
        if ({a_ok, a_err, a_cnt} !== {1'b1, 3'b000, 8'd2}) begin
            n_fail++;
            $display("FAIL gap_second_ok: got ok=%b err=%b cnt=%0d want 1 000 2", a_ok, a_err, a_cnt);
        end
`ifdef PULSE_CHK_ERRCNT_EN
        n_checks++;
        if (a_ecnt !== 8'd3) begin
            n_fail++;
            $display("FAIL gap_errcnt: got %0d want 3", a_ecnt);
        end
`endif
    endtask

    task automatic test_gap_len1();
        for (int i = 0; i < 3; i++) step(1'b1);
        step(1'b0);
        n_checks++;
        if ({c_ok, c_err, c_busy} !== {1'b1, 3'b000, 1'b0}) begin
            n_fail++;
            $display("FAIL gap1_ok: got ok=%b err=%b busy=%b want 1 000 0", c_ok, c_err, c_busy);
        end
        step(1'b0);
        n_checks++;
        if ({c_ok, a_ok, a_cnt, b_cnt} !== {1'b0, 1'b1, 8'd3, 2'd3}) begin
            n_fail++;
            $display("FAIL gap1_after: got c_ok=%b a_ok=%b cnt=%0d/%0d want 0 1 3/3",
                     c_ok, a_ok, a_cnt, b_cnt);
        end
    endtask

    task automatic test_saturation();
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 3; i++) step(1'b1);
            step(1'b0);
            step(1'b0);
            n_checks++;
            if ({b_ok, b_cnt, a_cnt} !== {1'b1, 2'd3, 8'(4 + p)}) begin
                n_fail++;
                $display("FAIL sat[%0d]: got b_ok=%b b_cnt=%0d a_cnt=%0d want 1 3 %0d",
                         p, b_ok, b_cnt, a_cnt, 4 + p);
            end
            step(1'b0);
        end
    endtask

    task automatic test_clr();
        for (int i = 0; i < 3; i++) step(1'b1);
        step(1'b0);
        clr = 1'b1;
        step(1'b0);
        clr = 1'b0;
        n_checks++;
        if ({a_ok, a_cnt, b_cnt} !== {1'b1, 8'd0, 2'd0}) begin
            n_fail++;
            $display("FAIL clr_priority: got ok=%b cnt=%0d/%0d want 1 0/0", a_ok, a_cnt, b_cnt);
        end
`ifdef PULSE_CHK_ERRCNT_EN
        n_checks++;
        if ({a_ecnt, a_sticky} !== 9'd0) begin
            n_fail++;
            $display("FAIL clr_errcnt: got cnt=%0d sticky=%b want 0 0", a_ecnt, a_sticky);
        end
`endif
        step(1'b0);
        n_checks++;
        if ({a_ok, a_cnt, a_busy} !== 10'd0) begin
            n_fail++;
            $display("FAIL clr_after: got ok=%b cnt=%0d busy=%b want 0", a_ok, a_cnt, a_busy);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        clr      = 1'b0;
        y_in     = 1'b0;
        test_reset();
        test_nominal();
        test_short();
        test_long();
        test_gap();
        test_gap_len1();
        test_saturation();
        test_clr();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pulse_frame_checker.md
Name: pulse_frame_checker

Overview:
- Receive-side monitor for the single-wire pulse line driven by the trigger-to-pulse generator. That generator drives a 3-cycle high pulse followed by at least a 2-cycle low gap.
- Samples the line every clock and checks each pulse's high width and trailing gap.
- Emits a one-cycle strobe for each valid pulse, plus per-error-class strobes, and keeps a saturating count of good pulses.
- Sits in the same clock domain as the generator, so there is no synchronizer; used as a link checker and self-test observer.

Parameters:
- HIGH_LEN, 3, required high width of a valid pulse in clock cycles (1..(2**LEN_W)-2).
- GAP_LEN, 2, minimum low cycles after the falling edge before a pulse counts as valid (1..(2**LEN_W)-1).
- LEN_W, 4, width of the internal high and gap counters.
- CNT_W, 8, width of the good-pulse (and error) counters.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- clr  input  1  synchronous clear of ok_count (and err_count); has no effect on FSM state
- y_in  input  1  monitored pulse line
- busy  output  1  high whenever the FSM is not in IDLE
- pulse_ok  output  1  one-cycle strobe: valid pulse plus gap completed
- err_short  output  1  one-cycle strobe: high phase ended before HIGH_LEN
- err_long  output  1  one-cycle strobe: high phase exceeded HIGH_LEN
- err_gap  output  1  one-cycle strobe: line rose again before GAP_LEN low cycles
- ok_count  output  CNT_W  saturating count of pulse_ok strobes

Behaviour:
- Reset: reset=0 asynchronously forces state=IDLE, hcnt=0, gcnt=0. All outputs go to 0: busy, pulse_ok, err_*, ok_count.
- Outputs are registered. Strobes are high for exactly one cycle, in the cycle after the sampling edge that caused them.
- busy is decoded from the state register, so it is low exactly while in IDLE.
- IDLE:
  - y_in=1 -> HIGH, hcnt=1.
  - y_in=0 -> remain in IDLE.
- HIGH:
  - y_in=1 and hcnt<HIGH_LEN -> hcnt+1.
  - y_in=1 and hcnt==HIGH_LEN -> err_long, go to RECOVER.
  - y_in=0 and hcnt==HIGH_LEN -> GAP, gcnt=1.
  - y_in=0 and hcnt<HIGH_LEN -> err_short, go to IDLE.
- GAP:
  - y_in=0 and gcnt<GAP_LEN-1 -> gcnt+1.
  - y_in=0 and gcnt==GAP_LEN-1 -> pulse_ok, increment ok_count, go to IDLE.
  - y_in=1 -> err_gap, go to HIGH with hcnt=1. The rising edge is treated as the start of a new pulse.
  - Special case GAP_LEN=1: the pulse_ok check is made on the HIGH->GAP transition itself. pulse_ok fires on that edge and the next state is IDLE.
- RECOVER:
  - Hold while y_in=1; no further strobes.
  - y_in=0 -> IDLE.
- Counter rules:
  - ok_count saturates at all-ones; further pulse_ok strobes still pulse but do not wrap the count.
  - clr has priority over a same-cycle increment: the result is 0.
- Reset mid-pulse returns to IDLE. If y_in is still high when reset releases, IDLE sees y_in=1 and starts a fresh HIGH count. A truncated pulse may therefore be flagged err_short or err_long; this is accepted.
- Only one strobe can assert in any cycle; the FSM guarantees this.
- Reference timing (defaults):
  - y_in high at sampling edges k, k+1, k+2, low at k+3 and k+4.
  - HIGH at k..k+2, GAP after k+3.
  - pulse_ok is high in the cycle after edge k+4; ok_count increments at the same edge.
- Unused FSM encodings decode to IDLE.

Optional Feature:
- Macro: PULSE_CHK_ERRCNT_EN.
- When defined:
  - Adds output err_count [CNT_W].
  - err_count increments (saturating) on each err_short, err_long or err_gap strobe.
  - It is reset to 0 by reset or clr.
  - Adds output err_sticky, set by any error strobe and cleared only by reset or clr.
- When undefined: neither port exists, and there is no related logic.

Test Plan:
- Reset: hold reset=0 with y_in toggling -> all outputs 0 and busy=0. Release with y_in=0 -> still IDLE.
- Nominal pulse (defaults): y_in=1 for 3 cycles, then 0 for 2 or more cycles -> exactly one pulse_ok, 5 cycles after the rising sample. ok_count=1, no err_*.
- Short pulse: y_in=1 for 2 cycles, then 0 -> err_short on the cycle after the falling sample, ok_count unchanged, busy=0 next cycle.
- Long pulse: y_in=1 for 6 cycles -> err_long after the 4th high sample, busy stays 1 until y_in falls, then IDLE with no second error.
- Gap violation: 3 high, 1 low, then 3 high, 2 low -> err_gap on the second rise, followed by pulse_ok for the second pulse. ok_count=1.
- Saturation and clear: CNT_W=2, 5 nominal pulses -> ok_count sticks at 3. Asserting clr on the same cycle as a pulse_ok increment -> ok_count=0. With PULSE_CHK_ERRCNT_EN, rerun the short-pulse case -> err_count=1, err_sticky=1.
